// File: rtl/slow_event_arbiter.sv
// Round-robin arbiter that shares one fast-to-slow event strobe between N_REQ requesters.
// Optional watchdog abort is built only when SLOW_EVT_TIMEOUT_EN is defined.
module slow_event_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             slowClk,
    output logic             out,
    output logic [ID_W-1:0]  out_id,
    output logic [N_REQ-1:0] ack,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOW  = 3'd1,
        ST_WAIT_HIGH = 3'd2,
        ST_ACK       = 3'd3,
        ST_GAP_LOW   = 3'd4,
        ST_GAP_HIGH  = 3'd5
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   grant_r;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   pick_s;
    logic              pick_vld_s;
    logic              timed_hold_s;
    logic              tmo_s;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        if (int'(idx) >= N_REQ - 1) begin
            next_idx = '0;
        end else begin
            next_idx = idx + ID_W'(1);
        end
    endfunction

    // First pending requester at or after rr_ptr_r, wrapping; scanning downwards lets the nearest one win.
    always_comb begin : arb_pick
        int idx_v;
        pick_s     = '0;
        pick_vld_s = 1'b0;
        idx_v      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_v = (int'(rr_ptr_r) + k) % N_REQ;
            if (req[idx_v[ID_W-1:0]]) begin
                pick_s     = idx_v[ID_W-1:0];
                pick_vld_s = 1'b1;
            end else begin
                pick_s     = pick_s;
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // A timed state holds while slowClk has not yet reached the level that state waits for.
    always_comb begin
        case (state_r)
            ST_WAIT_LOW, ST_GAP_LOW:   timed_hold_s = slowClk;
            ST_WAIT_HIGH, ST_GAP_HIGH: timed_hold_s = ~slowClk;
            default:                   timed_hold_s = 1'b0;
        endcase
    end

`ifdef SLOW_EVT_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    assign tmo_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES));
    assign err   = err_r;

    // Watchdog: counts cycles spent in one timed state, cleared whenever the state changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            err_r <= tmo_s && ((state_r == ST_WAIT_LOW) || (state_r == ST_WAIT_HIGH));
            if (tmo_s || !timed_hold_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end
`else
    assign tmo_s = 1'b0;
    assign err   = 1'b0;
`endif

    // Event sequencer: grant, hold the strobe across a slow low then high phase, ack, then a full slow gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
            out      <= 1'b0;
            out_id   <= '0;
            ack      <= '0;
            busy     <= 1'b0;
        end else begin
            ack <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_r <= ST_WAIT_LOW;
                        grant_r <= pick_s;
                        out     <= 1'b1;
                        out_id  <= pick_s;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        out     <= 1'b0;
                        out_id  <= '0;
                        busy    <= 1'b0;
                    end
                end
                ST_WAIT_LOW, ST_WAIT_HIGH: begin
                    if (tmo_s) begin
                        // Abort without ack; the requester keeps its bit and re-arbitrates later.
                        state_r  <= ST_GAP_LOW;
                        out      <= 1'b0;
                        out_id   <= '0;
                        rr_ptr_r <= next_idx(grant_r);
                    end else if (timed_hold_s) begin
                        state_r <= state_r;
                    end else if (state_r == ST_WAIT_LOW) begin
                        state_r <= ST_WAIT_HIGH;
                    end else begin
                        state_r  <= ST_ACK;
                        out      <= 1'b0;
                        out_id   <= '0;
                        ack      <= N_REQ'(1) << grant_r;
                        rr_ptr_r <= next_idx(grant_r);
                    end
                end
                ST_ACK: begin
                    state_r <= ST_GAP_LOW;
                end
                ST_GAP_LOW, ST_GAP_HIGH: begin
                    if (tmo_s || (!timed_hold_s && (state_r == ST_GAP_HIGH))) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (timed_hold_s) begin
                        state_r <= state_r;
                    end else begin
                        state_r <= ST_GAP_HIGH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    out     <= 1'b0;
                    out_id  <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_event_arbiter.sv
// Self-checking bench for slow_event_arbiter: event-level model compared every cycle plus directed checks.
// The watchdog scenario runs only when SLOW_EVT_TIMEOUT_EN is defined.
module tb_slow_event_arbiter;

    localparam int N = 4;
    localparam int T = 20;
`ifdef SLOW_EVT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       slowClk;
    logic       out;
    logic [1:0] out_id;
    logic [3:0] ack;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;
    bit slow_run = 1'b1;
    bit slow_hold = 1'b1;

    slow_event_arbiter #(
        .N_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(T), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .slowClk(slowClk),
        .out(out), .out_id(out_id), .ack(ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // slowClk: period of 16 clk when running, otherwise held at slow_hold
    initial begin
        int ph;
        ph = 0;
        slowClk = 1'b0;
        forever begin
            @(negedge clk);
            if (slow_run) begin
                ph++;
                if (ph == 8) begin
                    ph = 0;
                    slowClk = ~slowClk;
                end
            end else begin
                ph = 0;
                slowClk = slow_hold;
            end
        end
    end

    // Event-level model: milestones 0 need low, 1 need high, 2 ack, 3 gap needs low, 4 gap needs high
    bit m_act;
    bit m_err;
    int m_grant, m_stage, m_ptr, m_wait;

    always @(posedge clk) begin
        m_err = 1'b0;
        if (reset) begin
            m_act = 1'b0; m_ptr = 0; m_stage = 0; m_wait = 0; m_grant = 0;
        end else if (!m_act) begin
            if (req != 4'b0000) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
                m_act = 1'b1; m_stage = 0; m_wait = 0;
            end
        end else if (m_stage == 2) begin
            m_stage = 3; m_wait = 0;
        end else if (TMO_EN && m_wait == T) begin
            if (m_stage < 2) begin
                m_err = 1'b1; m_ptr = (m_grant + 1) % N; m_stage = 3;
            end else begin
                m_act = 1'b0;
            end
            m_wait = 0;
        end else if (slowClk == ((m_stage == 0 || m_stage == 3) ? 1'b0 : 1'b1)) begin
            if (m_stage == 1) m_ptr = (m_grant + 1) % N;
            if (m_stage == 4) m_act = 1'b0;
            else m_stage++;
            m_wait = 0;
        end else begin
            m_wait++;
        end
    end

    // Compare DUT outputs to the model on every falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            logic       e_out;
            logic [1:0] e_id;
            logic [3:0] e_ack;
            e_out = m_act && (m_stage < 2);
            e_id  = e_out ? 2'(m_grant) : 2'd0;
            e_ack = (m_act && m_stage == 2) ? (4'b0001 << m_grant) : 4'b0000;
            n_checks++;
            if (out !== e_out || out_id !== e_id || ack !== e_ack || busy !== m_act || err !== m_err) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got out=%b id=%0d ack=%b busy=%b err=%b required out=%b id=%0d ack=%b busy=%b err=%b",
                         $time, out, out_id, ack, busy, err, e_out, e_id, e_ack, m_act, m_err);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ack(output int idx);
        int n;
        idx = -1;
        n = 0;
        do begin
            step();
            n++;
        end while (ack == 4'b0000 && n < 80);
        if (ack == 4'b0000) begin
            n_checks++; n_err++;
            $display("FAIL ack_timeout: no ack within %0d cycles", n);
        end else begin
            for (int b = 0; b < N; b++) if (ack[b]) idx = b;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 80) begin
            step();
            n++;
        end
        if (busy) begin
            n_checks++; n_err++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_wait_high();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(out && !slowClk) && n < 60);
        step();
    endtask

    initial begin
        int idx, gap, cnt, a2;
        int log_q[$];
        reset = 1'b1;
        req   = 4'b0000;
        step();
        cmp_en = 1'b1;
        step();
        // 1: reset state
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_id", out_id, 0);
        reset = 1'b0;

        // 2: single request, one clk latency, ack, full slow gap
        step();
        req = 4'b0010;
        step();
        chk("t2_out", out, 1);
        chk("t2_id", out_id, 1);
        wait_ack(idx);
        chk("t2_ack", ack, 4'b0010);
        req = 4'b0000;
        gap = 1;
        while (busy && gap < 80) begin
            step();
            if (busy) gap++;
            if (out) chk("t2_gap_out", out, 0);
        end
        chk("t2_gap_len", gap, 16);
        chk("t2_idle_busy", busy, 0);

        // 3: round robin over 4'b1011 from rr_ptr=0
        do_reset();
        req = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            wait_ack(idx);
            log_q.push_back(idx);
            if (idx >= 0) req[idx] = 1'b0;
        end
        req = 4'b0001;
        wait_ack(idx);
        log_q.push_back(idx);
        req = 4'b0000;
        chk("t3_nacks", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("t3_g0", log_q[0], 0);
            chk("t3_g1", log_q[1], 1);
            chk("t3_g2", log_q[2], 3);
            chk("t3_g3", log_q[3], 0);
        end
        wait_idle();

        // 4: req[2] dropped during WAIT_HIGH still yields exactly one ack
        step();
        req = 4'b0100;
        wait_wait_high();
        chk("t4_in_event", out, 1);
        chk("t4_id", out_id, 2);
        req = 4'b0000;
        a2 = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ack[2]) a2++;
        end
        chk("t4_ack_count", a2, 1);
        chk("t4_idle", busy, 0);

        // 5: reset during WAIT_HIGH aborts; rr_ptr returns to 0 (rr_ptr is 3 before this)
        req = 4'b0100;
        wait_wait_high();
        chk("t5_in_event", out, 1);
        reset = 1'b1;
        step();
        chk("t5_out", out, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ack", ack, 0);
        reset = 1'b0;
        req = 4'b1001;
        step();
        chk("t5_regrant_out", out, 1);
        chk("t5_regrant_id", out_id, 0);
        wait_ack(idx);
        chk("t5_ack_idx", idx, 0);
        req = 4'b0000;
        wait_idle();

`ifdef SLOW_EVT_TIMEOUT_EN
        // 6: slowClk stuck high, watchdog aborts WAIT_LOW then GAP_LOW
        do_reset();
        slow_run  = 1'b0;
        slow_hold = 1'b1;
        step();
        req = 4'b0100;
        step();
        chk("t6_out", out, 1);
        cnt = 1;
        while (out && cnt < 100) begin
            step();
            if (out) cnt++;
            if (ack != 4'b0000) chk("t6_no_ack", ack, 0);
        end
        chk("t6_wait_len", cnt, 21);
        chk("t6_err", err, 1);
        chk("t6_err_ack", ack, 0);
        gap = 1;
        while (busy && gap < 100) begin
            step();
            if (busy) gap++;
        end
        chk("t6_gap_len", gap, 21);
        chk("t6_idle_out", out, 0);
        step();
        chk("t6_regrant_out", out, 1);
        chk("t6_regrant_id", out_id, 2);
        req = 4'b0000;
        slow_run = 1'b1;
        wait_ack(idx);
        chk("t6_final_ack", idx, 2);
        wait_idle();
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
